alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (req0, req1).
//  - Round-robin grant, valid/ready handshakes on both requests and on the response.
//  - Drives the ALU operand/control inputs and registers the result plus N/Z/C/V flags.
//  - Returns result and flags on a single tagged response port.
//  - Sits between the issue logic and the shared ALU; ALU is instantiated outside this block.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one external ALU between two requesters
//
// Purpose: arbitrates req0/req1 onto a shared combinational ALU, registers the
// result and {n,z,c,v} flags into a single-entry tagged response, and counts
// grants per requester with saturating counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/ready          request handshake per requester
//   req{0,1}_x/y/ctrl             request operands and ALU control code
//   alu_x/y/ctrl                  drive to the external ALU (zero when idle)
//   alu_result, alu_nzcv          combinational ALU outputs
//   rsp_valid/ready               response handshake
//   rsp_id/result/nzcv            tagged, registered response payload
//   grant_cnt0/1                  saturating grant counters
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_x,
    input  logic [DATA_WIDTH-1:0] req0_y,
    input  logic [3:0]            req0_ctrl,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_x,
    input  logic [DATA_WIDTH-1:0] req1_y,
    input  logic [3:0]            req1_ctrl,
    output logic [DATA_WIDTH-1:0] alu_x,
    output logic [DATA_WIDTH-1:0] alu_y,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [3:0]            alu_nzcv,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [3:0]            rsp_nzcv,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            state_q,      state_d;
    logic                  rsp_id_q,     rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]            rsp_nzcv_q,   rsp_nzcv_d;
    logic                  rr_ptr_q,     rr_ptr_d;
    logic [CNT_WIDTH-1:0]  grant_cnt0_q, grant_cnt0_d;
    logic [CNT_WIDTH-1:0]  grant_cnt1_q, grant_cnt1_d;

    logic can_issue;
    logic grant0;
    logic grant1;

    // A held response frees its slot in the same cycle it is consumed, which is
    // what lets a new op be accepted back-to-back at one per cycle.
    always_comb begin
        can_issue = !rst && ((state_q == ST_EMPTY) || rsp_ready);
        grant0    = can_issue && req0_valid && (!req1_valid || !rr_ptr_q);
        grant1    = can_issue && req1_valid && (!req0_valid ||  rr_ptr_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_x    = '0;
        alu_y    = '0;
        alu_ctrl = '0;
        if (grant0) begin
            alu_x    = req0_x;
            alu_y    = req0_y;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_x    = req1_x;
            alu_y    = req1_y;
            alu_ctrl = req1_ctrl;
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_nzcv_d   = rsp_nzcv_q;
        rr_ptr_d     = rr_ptr_q;
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (grant0 || grant1) begin
            state_d      = ST_FULL;
            rsp_id_d     = grant1;
            rsp_result_d = alu_result;
            rsp_nzcv_d   = alu_nzcv;
            // Next tie goes to whoever did not just win.
            rr_ptr_d     = grant0;
            if (grant0 && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + CNT_ONE;
            if (grant1 && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + CNT_ONE;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_nzcv_q   <= '0;
            rr_ptr_q     <= 1'b0;
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_nzcv_q   <= rsp_nzcv_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_nzcv   = rsp_nzcv_q;
    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int DW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [DW-1:0] req0_x, req0_y;
    logic [3:0]    req0_ctrl;
    logic          req1_valid, req1_ready;
    logic [DW-1:0] req1_x, req1_y;
    logic [3:0]    req1_ctrl;
    logic [DW-1:0] alu_x, alu_y, alu_result;
    logic [3:0]    alu_ctrl, alu_nzcv;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_result;
    logic [3:0]    rsp_nzcv;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_ctrl(req1_ctrl),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_nzcv(alu_nzcv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_nzcv(rsp_nzcv),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Reference ALU: returns {n,z,c,v,result}; carry on subtract means "no borrow".
    function automatic logic [35:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, v;
        s  = '0;
        cy = 1'b0;
        v  = 1'b0;
        case (c)
            OP_ADD: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[31:0];
                cy = s[32];
                v  = (x[31] == y[31]) && (r[31] != x[31]);
            end
            OP_SUB: begin
                r  = x - y;
                cy = (x >= y);
                v  = (x[31] != y[31]) && (r[31] != x[31]);
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), cy, v, r};
    endfunction

    logic [35:0] alu_out;
    always_comb alu_out = alu_fn(alu_x, alu_y, alu_ctrl);
    assign alu_result = alu_out[31:0];
    assign alu_nzcv   = alu_out[35:32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: one response slot, the loser of the last tie-break rule, and counts.
    bit          m_full = 0;
    int          m_tie  = 0;
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;
    bit          m_id   = 0;
    logic [35:0] m_out  = '0;

    always @(negedge clk) begin
        int          win;
        logic [31:0] ex, ey;
        logic [3:0]  ec;
        win = -1;
        if (!rst && (!m_full || rsp_ready)) begin
            if (req0_valid && req1_valid) win = m_tie;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        ex = (win == 0) ? req0_x    : (win == 1) ? req1_x    : '0;
        ey = (win == 0) ? req0_y    : (win == 1) ? req1_y    : '0;
        ec = (win == 0) ? req0_ctrl : (win == 1) ? req1_ctrl : '0;

        chk("req0_ready", req0_ready, win == 0);
        chk("req1_ready", req1_ready, win == 1);
        chk("alu_x", alu_x, ex);
        chk("alu_y", alu_y, ey);
        chk("alu_ctrl", alu_ctrl, ec);
        chk("rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_out[31:0]);
            chk("rsp_nzcv", rsp_nzcv, m_out[35:32]);
        end
        chk("grant_cnt0", grant_cnt0, m_cnt0);
        chk("grant_cnt1", grant_cnt1, m_cnt1);

        if (rst) begin
            m_full = 0; m_tie = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (win >= 0) begin
            m_full = 1;
            m_id   = (win == 1);
            m_out  = alu_fn(ex, ey, ec);
            m_tie  = 1 - win;
            if (win == 0) m_cnt0 = (m_cnt0 < CNT_MAX) ? m_cnt0 + 1 : CNT_MAX;
            else          m_cnt1 = (m_cnt1 < CNT_MAX) ? m_cnt1 + 1 : CNT_MAX;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    end

    task automatic set_in(input bit v0, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [3:0] c0, input bit v1, input logic [31:0] x1,
                          input logic [31:0] y1, input logic [3:0] c1, input bit rr);
        req0_valid = v0; req0_x = x0; req0_y = y0; req0_ctrl = c0;
        req1_valid = v1; req1_x = x1; req1_y = y1; req1_ctrl = c1;
        rsp_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rr);
        set_in(0, 0, 0, OP_AND, 0, 0, 0, OP_AND, rr);
    endtask

    initial begin
        rst = 1'b1;
        // Op presented during reset must not be accepted.
        set_in(1, 32'd1, 32'd2, OP_ADD, 0, 0, 0, OP_AND, 1);
        #1;
        chk("lit_ready0_in_rst", req0_ready, 0);
        chk("lit_alu_x_in_rst", alu_x, 0);
        tick(); tick();
        chk("lit_rst_valid", rsp_valid, 0);
        chk("lit_rst_cnt0", grant_cnt0, 0);
        rst = 1'b0;

        // Single add from req0.
        set_in(1, 32'd5, 32'd7, OP_ADD, 0, 0, 0, OP_AND, 1);
        tick();
        chk("lit_add_valid", rsp_valid, 1);
        chk("lit_add_id", rsp_id, 0);
        chk("lit_add_result", rsp_result, 12);
        chk("lit_add_nzcv", rsp_nzcv, 4'b0000);
        idle(1);
        tick();
        chk("lit_drain", rsp_valid, 0);

        // Continuous tie with the consumer always ready: alternate 0,1,0,1.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, i, 32'd10, OP_ADD, 1, 32'd20, i, OP_SUB, 1);
            tick();
            chk("lit_rr_id", rsp_id, i % 2);
            chk("lit_rr_valid", rsp_valid, 1);
        end
        chk("lit_rr_cnt0", grant_cnt0, 2);
        chk("lit_rr_cnt1", grant_cnt1, 2);
        idle(1);
        tick();

        // Backpressure: 3-3 held for three cycles while req1 waits.
        set_in(0, 0, 0, OP_AND, 1, 32'd3, 32'd3, OP_SUB, 0);
        tick();
        set_in(0, 0, 0, OP_AND, 1, 32'd9, 32'd4, OP_SUB, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lit_bp_ready1", req1_ready, 0);
            chk("lit_bp_result", rsp_result, 0);
            chk("lit_bp_nzcv", rsp_nzcv, 4'b0110);
            chk("lit_bp_id", rsp_id, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("lit_bp_accept", req1_ready, 1);
        tick();
        chk("lit_bp_result2", rsp_result, 5);
        chk("lit_bp_nzcv2", rsp_nzcv, 4'b0010);

        // Signed overflow on add.
        set_in(1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 0, 0, 0, OP_AND, 1);
        tick();
        chk("lit_ovf_result", rsp_result, 32'h8000_0000);
        chk("lit_ovf_nzcv", rsp_nzcv, 4'b1001);

        // Reset while a response is held; then the first tie goes to req0.
        set_in(1, 32'd1, 32'd1, OP_OR, 1, 32'd2, 32'd2, OP_OR, 0);
        rst = 1'b1;
        #1;
        chk("lit_rstfull_ready0", req0_ready, 0);
        tick();
        rst = 1'b0;
        chk("lit_rstfull_valid", rsp_valid, 0);
        chk("lit_rstfull_cnt0", grant_cnt0, 0);
        chk("lit_rstfull_cnt1", grant_cnt1, 0);
        rsp_ready = 1'b1;
        #1;
        chk("lit_tie_ready0", req0_ready, 1);
        chk("lit_tie_ready1", req1_ready, 0);
        tick();
        chk("lit_tie_id", rsp_id, 0);

        // Saturation: five grants to req0 leave a 2-bit counter at 3.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1, i, 32'd3, OP_AND, 0, 0, 0, OP_AND, 1);
            tick();
        end
        chk("lit_sat_cnt0", grant_cnt0, 3);
        chk("lit_sat_cnt1", grant_cnt1, 0);
        idle(1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
